// File: rtl/ks_addsub_pipe.sv
// Three-stage pipelined Kogge-Stone adder/subtractor with valid/ready on both sides.
// Subtraction is A + ~B + 1, with the carry-in folded into the bit-0 generate term.
module ks_addsub_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cflag,
  output logic             ovf,
  output logic             zero
);

  localparam int L  = $clog2(WIDTH);
  localparam int L1 = (L + 1) / 2;

  // Handshake: a beat moves across either boundary on a rising edge where
  // valid and ready are both high. The pipeline is a single shift chain that
  // advances only when the output slot is empty or being drained this cycle,
  // so in_ready is that same advance term and never depends on in_valid.
  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // ---------------- stage 1: bitwise generate/propagate ----------------
  logic [WIDTH-1:0] bm;
  logic [WIDTH-1:0] g_in;
  logic [WIDTH-1:0] p_in;

  always_comb begin
    bm      = b ^ {WIDTH{sub}};
    p_in    = a ^ bm;
    g_in    = a & bm;
    g_in[0] = g_in[0] | (p_in[0] & sub);
  end

  logic             v1;
  logic [WIDTH-1:0] g1;
  logic [WIDTH-1:0] p1;
  logic             sub1;
  logic             sa1;
  logic             sb1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0;
    end else if (adv) begin
      v1   <= in_valid;
      g1   <= g_in;
      p1   <= p_in;
      sub1 <= sub;
      sa1  <= a[WIDTH-1];
      sb1  <= bm[WIDTH-1];
    end
  end

  // ---------------- stage 2: first half of the prefix tree ----------------
  // Descending bit order lets each level update in place: bit i reads bit
  // i-span before that lower bit is overwritten. Groups that already reach
  // bit 0 (gray cells) only need G, so their P is left as-is.
  logic [WIDTH-1:0] g_mid;
  logic [WIDTH-1:0] p_mid;

  always_comb begin
    g_mid = g1;
    p_mid = p1;
    for (int k = 0; k < L1; k++) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (i >= (1 << k)) begin
          g_mid[i] = g_mid[i] | (p_mid[i] & g_mid[i - (1 << k)]);
          if (i >= (2 << k)) begin
            p_mid[i] = p_mid[i] & p_mid[i - (1 << k)];
          end
        end
      end
    end
  end

  logic             v2;
  logic [WIDTH-1:0] g2;
  logic [WIDTH-1:0] p2;
  logic [WIDTH-1:0] po2;
  logic             sub2;
  logic             sa2;
  logic             sb2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2 <= 1'b0;
    end else if (adv) begin
      v2   <= v1;
      g2   <= g_mid;
      p2   <= p_mid;
      po2  <= p1;
      sub2 <= sub1;
      sa2  <= sa1;
      sb2  <= sb1;
    end
  end

  // ---------------- stage 3: remaining levels, sum and flags ----------------
  logic [WIDTH-1:0] g_fin;
  logic [WIDTH-1:0] p_fin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf_nxt;

  always_comb begin
    g_fin = g2;
    p_fin = p2;
    for (int k = L1; k < L; k++) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (i >= (1 << k)) begin
          g_fin[i] = g_fin[i] | (p_fin[i] & g_fin[i - (1 << k)]);
          if (i >= (2 << k)) begin
            p_fin[i] = p_fin[i] & p_fin[i - (1 << k)];
          end
        end
      end
    end
    // g_fin[i] is now the carry out of bit i; the carry into bit 0 is sub.
    sum[0] = po2[0] ^ sub2;
    for (int i = 1; i < WIDTH; i++) begin
      sum[i] = po2[i] ^ g_fin[i - 1];
    end
    cout = g_fin[WIDTH-1];
    // Equal operand signs with a differing result sign; identical to
    // C(WIDTH-1) ^ C(WIDTH-2) since the MSB propagate is sa2 ^ sb2.
    ovf_nxt = ~(sa2 ^ sb2) & (sum[WIDTH-1] ^ sa2);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      s         <= '0;
      cflag     <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (adv) begin
      out_valid <= v2;
      if (v2) begin
        s     <= sum;
        cflag <= cout ^ sub2;
        ovf   <= ovf_nxt;
        zero  <= ~|sum;
      end
    end
  end

endmodule

// File: tb/tb_ks_addsub_pipe.sv
// Bench for ks_addsub_pipe: directed vectors with literal results, random
// streams with backpressure, and a mid-flight reset, checked against an arithmetic model.
module tb_ks_addsub_pipe;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cflag;
  logic         ovf;
  logic         zero;

  ks_addsub_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cflag(cflag), .ovf(ovf), .zero(zero)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  // Packed result {cflag, ovf, zero, s} from plain integer arithmetic.
  function automatic logic [W+2:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic ms);
    int unsigned ua;
    int unsigned ub;
    logic [W-1:0] r;
    logic c;
    logic o;
    ua = ma;
    ub = mb;
    if (ms) begin
      r = ma - mb;
      c = (ua < ub);
      o = (ma[W-1] != mb[W-1]) && (r[W-1] != ma[W-1]);
    end else begin
      r = ma + mb;
      c = ((ua + ub) >= (32'd1 << W));
      o = (ma[W-1] == mb[W-1]) && (r[W-1] != ma[W-1]);
    end
    return {c, o, (r == '0), r};
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic [W+2:0] exp_q[$];
  logic         mon_en = 1'b0;
  logic         prev_stall = 1'b0;
  logic [W+3:0] prev_out = '0;
  logic [W+3:0] cur_out;
  logic [W+2:0] exp_v;

  always @(negedge clk) begin
    if (mon_en) begin
      cur_out = {out_valid, cflag, ovf, zero, s};
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      if (prev_stall) chk("stall_hold", cur_out, prev_out);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_result: got %0h expected no beat (t=%0t)", s, $time);
        end else begin
          exp_v = exp_q.pop_front();
          chk("result", {cflag, ovf, zero, s}, exp_v);
        end
      end
      if (!rst_n) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(model(a, b, sub));
      prev_stall = out_valid && !out_ready && rst_n;
      prev_out   = cur_out;
    end
  end

  // ---------------- driver tasks ----------------
  logic rand_ready = 1'b0;

  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic drive_beat(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic ts);
    int waited = 0;
    in_valid = 1'b1;
    a = ta;
    b = tbv;
    sub = ts;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) fail_now("in_ready_timeout");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic directed(input string name, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                          input logic ts, input logic [W-1:0] es, input logic ec,
                          input logic eo, input logic ez);
    int lat = 1;
    drive_beat(ta, tbv, ts);
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, "_latency"}, lat, 3);
    chk({name, "_value"}, {cflag, ovf, zero, s}, {ec, eo, ez, es});
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) fail_now("drain_timeout");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int start;
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;
    out_ready = 1'b1;

    @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_outputs", {cflag, ovf, zero, s}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    directed("sub_5_3",       16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
    directed("sub_borrow",    16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    directed("sub_ovf",       16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    directed("add_ovf",       16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    directed("add_carry_zero",16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    directed("sub_equal",     16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
    directed("add_min_min",   16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    directed("add_plain",     16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    directed("sub_neg",       16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0);

    // Back-to-back stream: one beat accepted every cycle.
    start = cyc;
    for (int i = 0; i < 100; i++) begin
      drive_beat(W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)),
                 1'($urandom_range(0, 1)));
    end
    chk("stream_cycles", cyc - start, 100);
    drain();

    // Random backpressure and input gaps.
    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      drive_beat(W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)),
                 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rand_ready = 1'b0;
    drain();

    // Reset with three beats in flight, plus a beat offered during reset.
    drive_beat(16'h1111, 16'h0001, 1'b0);
    drive_beat(16'h2222, 16'h0002, 1'b1);
    drive_beat(16'h3333, 16'h0003, 1'b0);
    rst_n = 1'b0;
    in_valid = 1'b1;
    a = 16'hAAAA;
    b = 16'h5555;
    sub = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_outputs", {cflag, ovf, zero, s}, 0);
    directed("post_reset", 16'h0010, 16'h0001, 1'b1, 16'h000F, 1'b0, 1'b0, 1'b0);
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_out_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/ks_addsub_pipe.md
Name: ks_addsub_pipe

Overview:
- 3-stage pipelined WIDTH-bit Kogge-Stone adder/subtractor.
- Subtract mode computes A + ~B + 1. It reuses the generate/propagate prefix tree and the final sum cell, Si = Pi ^ C(i-1).
- Sits between operand-producing logic and the result consumer.
- Valid/ready handshake on both sides; full throughput of 1 op/cycle; backpressure supported.

Parameters:
- WIDTH, 16, operand width. Must be a power of two, 8..32. The prefix tree has log2(WIDTH) levels.

Ports:
- Clk  input  1  single clock; all state updates on rising edge.
- Rst_n  input  1  synchronous, active-low reset.
- In_valid  input  1  operand beat present.
- In_ready  output  1  block can accept a beat this cycle.
- A  input  WIDTH  minuend / augend.
- B  input  WIDTH  subtrahend / addend.
- Sub  input  1  1 = A-B, 0 = A+B. Sampled with the operands.
- Out_valid  output  1  result beat present.
- Out_ready  input  1  consumer accepts the result this cycle.
- S  output  WIDTH  difference / sum, modulo 2^WIDTH.
- Cflag  output  1  Sub=0: carry-out. Sub=1: borrow, i.e. ~carry-out.
- Ovf  output  1  two's-complement signed overflow.
- Zero  output  1  S == 0.

Behaviour:
- Reset: Clk with Rst_n=0 clears all stage valid bits and zeroes S, Cflag, Ovf, Zero. Out_valid=0 on the first cycle after reset.
  - In_ready is combinational and reads 1 whenever the output stage is empty, including during reset.
  - A beat presented during reset is discarded.
  - Reset mid-operation drops all in-flight beats; no partial results emerge.
- Advance condition: adv = ~Out_valid | Out_ready. The whole pipeline shifts only when adv=1 (global stall, no bubbles collapsed).
  - In_ready = adv.
  - A transfer occurs when In_valid & In_ready.
- Stage 1 register:
  - Bm = B ^ {WIDTH{Sub}}, Cin = Sub.
  - Gi = Ai & Bm_i, Pi = Ai ^ Bm_i.
  - Cin is folded into bit 0: G0' = G0 | (P0 & Cin).
  - Also registers Sub, sign bits A[MSB] and Bm[MSB], and the valid bit.
- Stage 2 register: first ceil(L/2) prefix levels, with L = log2(WIDTH), spans 1, 2, 4, ...
  - Black cell: G = Gh | (Ph & Gl), P = Ph & Pl.
  - Gray cell where span reaches bit 0.
  - Original Pi is carried along unchanged.
- Stage 3 register = outputs: remaining prefix levels, then:
  - C(i) = group G(i:0); C(-1) = Cin.
  - S_i = Pi ^ C(i-1).
  - Cout = C(WIDTH-1).
  - Cflag = Cout ^ Sub.
  - Ovf = C(WIDTH-1) ^ C(WIDTH-2).
  - Zero = ~|S.
- Latency: 3 cycles from input transfer to Out_valid when unstalled.
- Ordering: results emerge strictly in input order. Throughput is 1 beat/cycle when Out_ready is held high.
- Stall: while Out_valid=1 & Out_ready=0, all stage registers and outputs hold stable, and In_ready=0.
  - Out_ready rising releases the stall on that same cycle.
- Bubbles: a cycle with no input transfer while adv=1 inserts an invalid beat. Data registers may update but valid=0.
- Simultaneous accept and output: in one cycle with adv=1, a new beat enters stage 1 while stage 3 hands off. There is no loss and no duplication.
- Wrap-around: results are modulo 2^WIDTH. Overflow and borrow are reported only through Cflag and Ovf.

Test Plan:
- Reset, then Sub=1, A=0005, B=0003, Out_ready=1 -> 3 cycles later Out_valid=1, S=0002, Cflag=0, Ovf=0, Zero=0.
- Sub=1: A=0000, B=0001 -> S=FFFF, Cflag=1 (borrow). Next, A=8000, B=0001 -> S=7FFF, Ovf=1, Cflag=0.
- Sub=0: A=7FFF, B=0001 -> S=8000, Ovf=1, Cflag=0. Next, A=FFFF, B=0001 -> S=0000, Cflag=1, Zero=1.
- Stream 100 random beats back-to-back with Out_ready=1 -> In_ready stays 1, one result per cycle, and each result matches a reference model in order.
- Random Out_ready toggling with In_valid gaps -> no beat lost or duplicated, outputs stable during every stall cycle, and In_ready=0 exactly when Out_valid & ~Out_ready.
- Assert Rst_n=0 for 1 cycle with 3 beats in flight -> Out_valid=0 and all outputs zero the next cycle. No pre-reset result ever appears, and the first post-reset beat returns after 3 cycles.
